syn_counter_4bit: RTL and testbench

Free-running synchronous binary counter, WIDTH bits wide (default 4). It increments once on every rising clock edge and wraps modulo 2^WIDTH. A terminal-count flag marks the last state of each cycle. Intended as a lab-level timebase / sequence generator. Every bit toggles from the common clock through a ripple-free carry-enable chain, so all outputs change on the same edge.

---
 rtl/syn_counter_pkg.sv | 24 ++
 rtl/syn_counter_tff.sv | 17 +
 rtl/syn_counter_4bit.sv | 44 ++++
 tb/tb_syn_counter_4bit.sv | 134 +++++++++++++
 4 files changed

// File: rtl/syn_counter_pkg.sv
// Shared constants and terminal-value helpers for the syn_counter family.
// Terminal constants are 16 bits wide; callers slice them down to WIDTH.
package syn_counter_pkg;

    localparam int SYN_COUNTER_WIDTH_DEF = 4;
    localparam int SYN_COUNTER_WIDTH_MAX = 16;

    function automatic logic [SYN_COUNTER_WIDTH_MAX-1:0] all_ones(input int width);
        logic [SYN_COUNTER_WIDTH_MAX-1:0] v;
        v = '0;
        for (int i = 0; i < SYN_COUNTER_WIDTH_MAX; i++) begin
            if (i < width) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Expressed through all_ones so both helpers share one notion of width.
    function automatic logic [SYN_COUNTER_WIDTH_MAX-1:0] all_zeros(input int width);
        return all_ones(width) & ~all_ones(width);
    endfunction

endpackage

// File: rtl/syn_counter_tff.sv
// Single-bit toggle flip-flop with asynchronous active-low clear.
module syn_counter_tff (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/syn_counter_4bit.sv
// Free-running synchronous counter built from toggle flip-flops and a carry-enable chain.
// Define SYN_COUNTER_DOWN_EN to build a down-counter instead of the default up-counter.
module syn_counter_4bit
    import syn_counter_pkg::*;
#(
    parameter int WIDTH = SYN_COUNTER_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

`ifdef SYN_COUNTER_DOWN_EN
    localparam logic [SYN_COUNTER_WIDTH_MAX-1:0] TC_VALUE = all_zeros(WIDTH);
`else
    localparam logic [SYN_COUNTER_WIDTH_MAX-1:0] TC_VALUE = all_ones(WIDTH);
`endif

    logic [WIDTH-1:0] t;

    assign t[0] = 1'b1;

    // Chaining through t[i-1] gives the same AND-reduction over all lower bits.
    for (genvar i = 1; i < WIDTH; i++) begin : g_chain
`ifdef SYN_COUNTER_DOWN_EN
        assign t[i] = t[i-1] & ~q[i-1];
`else
        assign t[i] = t[i-1] & q[i-1];
`endif
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        syn_counter_tff u_tff (
            .clk   (clk),
            .reset (reset),
            .t     (t[i]),
            .q     (q[i])
        );
    end

    assign tc = (q == TC_VALUE[WIDTH-1:0]);

endmodule

// File: tb/tb_syn_counter_4bit.sv
// Directed bench for syn_counter_4bit: a default 4-bit instance and a 6-bit instance
// share clock and reset. Expected values follow the build direction (SYN_COUNTER_DOWN_EN).
module tb_syn_counter_4bit;

    logic       clk;
    logic       reset;
    logic       run;
    logic [3:0] q4;
    logic       tc4;
    logic [5:0] q6;
    logic       tc6;

    int compared   = 0;
    int mismatched = 0;
    int pulses4;
    int pulses6;

    syn_counter_4bit u_dut4 (
        .clk   (clk),
        .reset (reset),
        .q     (q4),
        .tc    (tc4)
    );

    syn_counter_4bit #(.WIDTH(6)) u_dut6 (
        .clk   (clk),
        .reset (reset),
        .q     (q6),
        .tc    (tc6)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (run) clk = ~clk;
    end

    // Count value after n edges from a cleared state, for the selected direction.
    function automatic logic [15:0] exp_q(input int n, input int w);
        int m;
        m = 1 << w;
`ifdef SYN_COUNTER_DOWN_EN
        return 16'((m - (n % m)) % m);
`else
        return 16'(n % m);
`endif
    endfunction

    function automatic logic [15:0] exp_tc(input int n, input int w);
`ifdef SYN_COUNTER_DOWN_EN
        return 16'(exp_q(n, w) == 16'd0);
`else
        return 16'(exp_q(n, w) == 16'((1 << w) - 1));
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        run   = 1'b0;
        reset = 1'b0;
        #10;
        checkOutput("reset_q4", 16'(q4), exp_q(0, 4));
        checkOutput("reset_tc4", 16'(tc4), exp_tc(0, 4));
        checkOutput("reset_q6", 16'(q6), exp_q(0, 6));
        #2;
        reset = 1'b1;
        run   = 1'b1;

        for (int i = 1; i <= 16; i++) begin
            tick();
            checkOutput($sformatf("count_q4_%0d", i), 16'(q4), exp_q(i, 4));
            checkOutput($sformatf("count_tc4_%0d", i), 16'(tc4), exp_tc(i, 4));
            checkOutput($sformatf("count_q6_%0d", i), 16'(q6), exp_q(i, 6));
        end

        // Counter is back at its start value; run to the cycle before wrap.
        for (int i = 1; i <= 15; i++) tick();
        checkOutput("wrap_pre_q4", 16'(q4), exp_q(15, 4));
        checkOutput("wrap_pre_tc4", 16'(tc4), exp_tc(15, 4));
        tick();
        checkOutput("wrap_post_q4", 16'(q4), exp_q(16, 4));
        checkOutput("wrap_post_tc4", 16'(tc4), exp_tc(16, 4));

        for (int i = 1; i <= 9; i++) tick();
        checkOutput("mid_before_q4", 16'(q4), exp_q(9, 4));
        #1 reset = 1'b0;
        #1;
        checkOutput("mid_async_q4", 16'(q4), 16'd0);
        checkOutput("mid_async_q6", 16'(q6), 16'd0);
        tick();
        checkOutput("mid_held1_q4", 16'(q4), 16'd0);
        tick();
        checkOutput("mid_held2_q4", 16'(q4), 16'd0);
        #1 reset = 1'b1;
        tick();
        checkOutput("mid_release_q4", 16'(q4), exp_q(1, 4));
        checkOutput("mid_release_q6", 16'(q6), exp_q(1, 6));

        #1 reset = 1'b0;
        #1 reset = 1'b1;
        checkOutput("long_start_q4", 16'(q4), 16'd0);
        pulses4 = 0;
        pulses6 = 0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (i <= 32 && tc4 === 1'b1) pulses4++;
            if (tc6 === 1'b1) pulses6++;
            if (i == 32) checkOutput("long_q4", 16'(q4), exp_q(32, 4));
            if (i == 63 || i == 64 || i == 1) begin
                checkOutput($sformatf("w6_q6_%0d", i), 16'(q6), exp_q(i, 6));
                checkOutput($sformatf("w6_tc6_%0d", i), 16'(tc6), exp_tc(i, 6));
            end
        end
        checkOutput("long_tc4_pulses", 16'(pulses4), 16'd2);
        checkOutput("w6_tc6_pulses", 16'(pulses6), 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
